// File: rtl/autobaud_ctrl_pkg.sv
// Shared definitions for the autobaud controller: one-hot state layout,
// counter width and the default glitch threshold.
package autobaud_ctrl_pkg;

    localparam int STATE_W         = 8;
    localparam int CNT_W           = 8;
    localparam int MIN_CNT_DEFAULT = 4;

    localparam int IDLE_IX      = 0;
    localparam int ARM_IX       = 1;
    localparam int WAIT_FALL_IX = 2;
    localparam int CLEAR_IX     = 3;
    localparam int MEASURE_IX   = 4;
    localparam int LOAD_IX      = 5;
    localparam int DONE_IX      = 6;
    localparam int ERR_IX       = 7;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE      = STATE_W'(1) << IDLE_IX,
        ST_ARM       = STATE_W'(1) << ARM_IX,
        ST_WAIT_FALL = STATE_W'(1) << WAIT_FALL_IX,
        ST_CLEAR     = STATE_W'(1) << CLEAR_IX,
        ST_MEASURE   = STATE_W'(1) << MEASURE_IX,
        ST_LOAD      = STATE_W'(1) << LOAD_IX,
        ST_DONE      = STATE_W'(1) << DONE_IX,
        ST_ERR       = STATE_W'(1) << ERR_IX
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

endpackage

// File: rtl/rx_sync_edge.sv
// Brings the asynchronous rx line into the clk domain and flags falling
// edges of the synchronized line.
module rx_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic rx_s,
    output logic fall
);

    logic meta_q;
    logic rx_s_q;
    logic rx_d_q;

    // NOTE: all three flops reset to the idle-high line level so that no
    // false falling edge appears when reset is released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b1;
            rx_s_q <= 1'b1;
            rx_d_q <= 1'b1;
        end else begin
            meta_q <= rx;
            rx_s_q <= meta_q;
            rx_d_q <= rx_s_q;
        end
    end

    assign rx_s = rx_s_q;
    assign fall = rx_d_q & ~rx_s_q;

endmodule

// File: rtl/autobaud_ctrl.sv
// Autobaud measurement controller: times the first low start bit on rx with
// an external 8-bit counter and loads the external N register with L-1.
module autobaud_ctrl
    import autobaud_ctrl_pkg::*;
#(
    parameter int MIN_CNT = MIN_CNT_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             rx,
    input  logic [CNT_W-1:0] cnt_q,
    output logic             cnt_en,
    output logic             cnt_rst,
    output logic             ld_en,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [CNT_W-1:0] MIN_CNT_V = CNT_W'(MIN_CNT);

    logic   rx_s;
    logic   fall;
    state_e state_q;

    rx_sync_edge u_rx_sync_edge (
        .clk  (clk),
        .rst  (rst),
        .rx   (rx),
        .rx_s (rx_s),
        .fall (fall)
    );

    // Abort outranks every other transition; start is only looked at in
    // IDLE, DONE and ERR.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else if (abort) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:      if (start) state_q <= ST_ARM;
                ST_ARM:       if (rx_s)  state_q <= ST_WAIT_FALL;
                ST_WAIT_FALL: if (fall)  state_q <= ST_CLEAR;
                ST_CLEAR:     state_q <= ST_MEASURE;
                ST_MEASURE: begin
                    if (rx_s) begin
                        state_q <= (cnt_q < MIN_CNT_V) ? ST_WAIT_FALL : ST_LOAD;
                    end else if (cnt_q == CNT_MAX) begin
                        state_q <= ST_ERR;
                    end
                end
                ST_LOAD:      state_q <= ST_DONE;
                ST_DONE:      if (start) state_q <= ST_ARM;
                ST_ERR:       if (start) state_q <= ST_ARM;
                default:      state_q <= ST_IDLE;
            endcase
        end
    end

    // Outputs come straight from state flops so cnt_rst can never glitch.
    assign cnt_rst = state_q[CLEAR_IX];
    assign cnt_en  = state_q[MEASURE_IX];
    assign ld_en   = state_q[LOAD_IX];
    assign done    = state_q[DONE_IX];
    assign err     = state_q[ERR_IX];
    assign busy    = state_q[ARM_IX] | state_q[WAIT_FALL_IX] | state_q[CLEAR_IX]
                   | state_q[MEASURE_IX] | state_q[LOAD_IX];

endmodule

// File: tb/tb_autobaud_ctrl.sv
// Bench for autobaud_ctrl: surrounds the controller with a counter and N
// register and checks measured N against the L-1 rule for each low pulse.
module tb_autobaud_ctrl;

    localparam int MIN_CNT = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] cnt_val;
    logic [7:0] n_val;
    logic       cnt_en, cnt_rst, ld_en, busy, done, err;

    int n_chk  = 0;
    int n_pass = 0;
    int n_clr  = 0;
    int n_en   = 0;
    int n_ld   = 0;
    int n_excl = 0;

    autobaud_ctrl #(.MIN_CNT(MIN_CNT)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .abort   (abort),
        .rx      (rx),
        .cnt_q   (cnt_val),
        .cnt_en  (cnt_en),
        .cnt_rst (cnt_rst),
        .ld_en   (ld_en),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    // Surrounding datapath: baud counter with async clear, and N register.
    always @(posedge clk or posedge cnt_rst or posedge rst) begin
        if (rst || cnt_rst) cnt_val <= 8'd0;
        else if (cnt_en)    cnt_val <= cnt_val + 8'd1;
    end

    always @(posedge clk or posedge rst) begin
        if (rst)        n_val <= 8'd0;
        else if (ld_en) n_val <= cnt_val;
    end

    always @(negedge clk) begin
        if (cnt_rst) n_clr++;
        if (cnt_en)  n_en++;
        if (ld_en)   n_ld++;
        if (int'(cnt_en) + int'(cnt_rst) + int'(ld_en) > 1) n_excl++;
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; rx = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(2);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(2);
    endtask

    // Drives rx low for len clocks then high for gap clocks.
    task automatic pulse(input int len, input int gap);
        rx = 1'b0;
        tick(len);
        rx = 1'b1;
        tick(gap);
    endtask

    // Cycles of cnt_en produced by one low interval of len cycles.
    function automatic int en_cycles(input int len);
        return ((len > 2) ? len : 2) - 1;
    endfunction

    task automatic test_reset();
        int b_clr;
        rst = 1'b1;
        tick(2);
        n_chk++; if ({cnt_en, cnt_rst, ld_en, busy, done, err} !== 6'b0) $display("FAIL reset_outputs got=%b exp=000000", {cnt_en, cnt_rst, ld_en, busy, done, err}); else n_pass++;
        rst = 1'b0;
        b_clr = n_clr;
        rx = 1'b0; tick(5); rx = 1'b1; tick(5);
        n_chk++; if ({cnt_en, cnt_rst, ld_en, busy, done, err} !== 6'b0) $display("FAIL reset_idle_outputs got=%b exp=000000", {cnt_en, cnt_rst, ld_en, busy, done, err}); else n_pass++;
        n_chk++; if (n_clr - b_clr !== 0) $display("FAIL reset_idle_no_clear got=%0d exp=0", n_clr - b_clr); else n_pass++;
    endtask

    task automatic test_basic();
        int b_clr, b_en, b_ld;
        apply_reset();
        b_clr = n_clr; b_en = n_en; b_ld = n_ld;
        do_start();
        n_chk++; if (busy !== 1'b1) $display("FAIL basic_busy_armed got=%b exp=1", busy); else n_pass++;
        pulse(100, 6);
        n_chk++; if (n_clr - b_clr !== 1) $display("FAIL basic_clr_pulses got=%0d exp=1", n_clr - b_clr); else n_pass++;
        n_chk++; if (n_en - b_en !== 99) $display("FAIL basic_en_cycles got=%0d exp=99", n_en - b_en); else n_pass++;
        n_chk++; if (n_ld - b_ld !== 1) $display("FAIL basic_ld_pulses got=%0d exp=1", n_ld - b_ld); else n_pass++;
        n_chk++; if (n_val !== 8'd99) $display("FAIL basic_n got=%0d exp=99", n_val); else n_pass++;
        n_chk++; if ({done, busy, err} !== 3'b100) $display("FAIL basic_flags got=%b exp=100", {done, busy, err}); else n_pass++;
    endtask

    task automatic test_glitch();
        int b_clr, b_ld;
        apply_reset();
        b_clr = n_clr; b_ld = n_ld;
        do_start();
        pulse(3, 5);
        n_chk++; if (n_ld - b_ld !== 0) $display("FAIL glitch_no_ld got=%0d exp=0", n_ld - b_ld); else n_pass++;
        n_chk++; if ({busy, done} !== 2'b10) $display("FAIL glitch_still_busy got=%b exp=10", {busy, done}); else n_pass++;
        pulse(50, 6);
        n_chk++; if (n_val !== 8'd49) $display("FAIL glitch_second_n got=%0d exp=49", n_val); else n_pass++;
        n_chk++; if ({done, n_clr - b_clr} !== {1'b1, 32'd2}) $display("FAIL glitch_done_clr got=%b/%0d exp=1/2", done, n_clr - b_clr); else n_pass++;
    endtask

    // Runs from the DONE state left by test_glitch, with N = 49.
    task automatic test_overflow();
        int b_en, b_ld;
        b_en = n_en; b_ld = n_ld;
        do_start();
        rx = 1'b0;
        tick(259);
        n_chk++; if (err !== 1'b0) $display("FAIL ovf_err_early got=%b exp=0", err); else n_pass++;
        tick();
        n_chk++; if (err !== 1'b1) $display("FAIL ovf_err_set got=%b exp=1", err); else n_pass++;
        tick(40);
        rx = 1'b1;
        tick(6);
        n_chk++; if ({err, busy, done} !== 3'b100) $display("FAIL ovf_flags got=%b exp=100", {err, busy, done}); else n_pass++;
        n_chk++; if (n_ld - b_ld !== 0) $display("FAIL ovf_no_ld got=%0d exp=0", n_ld - b_ld); else n_pass++;
        n_chk++; if (n_val !== 8'd49) $display("FAIL ovf_n_kept got=%0d exp=49", n_val); else n_pass++;
        n_chk++; if (n_en - b_en !== 256) $display("FAIL ovf_en_cycles got=%0d exp=256", n_en - b_en); else n_pass++;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_chk++; if ({busy, err} !== 2'b10) $display("FAIL ovf_restart got=%b exp=10", {busy, err}); else n_pass++;
    endtask

    task automatic test_arm_low();
        int b_clr, b_en;
        apply_reset();
        rx = 1'b0;
        tick(4);
        b_clr = n_clr; b_en = n_en;
        do_start();
        tick(10);
        n_chk++; if (busy !== 1'b1) $display("FAIL armlow_busy got=%b exp=1", busy); else n_pass++;
        n_chk++; if ((n_clr - b_clr) + (n_en - b_en) !== 0) $display("FAIL armlow_no_measure got=%0d exp=0", (n_clr - b_clr) + (n_en - b_en)); else n_pass++;
        rx = 1'b1;
        tick(6);
        pulse(20, 6);
        n_chk++; if ({n_val, done} !== {8'd19, 1'b1}) $display("FAIL armlow_n got=%0d/%b exp=19/1", n_val, done); else n_pass++;
    endtask

    task automatic wait_measure20(input string tag, output bit hit);
        int b_en;
        hit = 1'b0;
        b_en = n_en;
        for (int i = 0; i < 60; i++) begin
            if (n_en - b_en >= 20) begin
                hit = 1'b1;
                break;
            end
            tick();
        end
        n_chk++; if (!hit) $display("FAIL %s_timeout got=%0d exp=20 cnt_en cycles", tag, n_en - b_en); else n_pass++;
    endtask

    task automatic test_abort();
        int b_ld;
        bit hit;
        apply_reset();
        b_ld = n_ld;
        do_start();
        rx = 1'b0;
        wait_measure20("abort", hit);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_chk++; if ({cnt_en, busy, ld_en} !== 3'b000) $display("FAIL abort_outputs got=%b exp=000", {cnt_en, busy, ld_en}); else n_pass++;
        tick(5);
        rx = 1'b1;
        tick(8);
        n_chk++; if ({n_ld - b_ld, done, busy} !== {32'd0, 2'b00}) $display("FAIL abort_after got=%0d/%b/%b exp=0/0/0", n_ld - b_ld, done, busy); else n_pass++;
    endtask

    task automatic test_rst_mid();
        int b_ld, b_en, b_clr;
        bit hit;
        apply_reset();
        do_start();
        rx = 1'b0;
        wait_measure20("rstmid", hit);
        #2 rst = 1'b1;
        #1;
        n_chk++; if ({cnt_en, cnt_rst, ld_en, busy, done, err} !== 6'b0) $display("FAIL rstmid_immediate got=%b exp=000000", {cnt_en, cnt_rst, ld_en, busy, done, err}); else n_pass++;
        tick();
        rst = 1'b0;
        b_ld = n_ld; b_en = n_en; b_clr = n_clr;
        tick(4);
        rx = 1'b1;
        tick(20);
        n_chk++; if ((n_ld - b_ld) + (n_en - b_en) + (n_clr - b_clr) !== 0) $display("FAIL rstmid_spurious got=%0d exp=0", (n_ld - b_ld) + (n_en - b_en) + (n_clr - b_clr)); else n_pass++;
        n_chk++; if ({busy, done, err} !== 3'b000) $display("FAIL rstmid_idle got=%b exp=000", {busy, done, err}); else n_pass++;
    endtask

    task automatic test_boundary();
        int b_ld;
        apply_reset();
        b_ld = n_ld;
        do_start();
        pulse(MIN_CNT + 1, 4);
        n_chk++; if ({n_ld - b_ld, busy} !== {32'd0, 1'b1}) $display("FAIL bnd_min_plus1_glitch got=%0d/%b exp=0/1", n_ld - b_ld, busy); else n_pass++;
        pulse(MIN_CNT + 2, 6);
        n_chk++; if ({n_val, done} !== {8'(MIN_CNT + 1), 1'b1}) $display("FAIL bnd_min_plus2 got=%0d/%b exp=%0d/1", n_val, done, MIN_CNT + 1); else n_pass++;
        do_start();
        pulse(256, 6);
        n_chk++; if ({n_val, done, err} !== {8'd255, 2'b10}) $display("FAIL bnd_256 got=%0d/%b/%b exp=255/1/0", n_val, done, err); else n_pass++;
    endtask

    task automatic test_random();
        int b_clr, b_en, b_ld, exp_en, exp_clr, n_gl, g, len;
        apply_reset();
        for (int it = 0; it < 6; it++) begin
            b_clr = n_clr; b_en = n_en; b_ld = n_ld;
            exp_en = 0; exp_clr = 0;
            do_start();
            n_gl = $urandom_range(0, 2);
            for (int k = 0; k < n_gl; k++) begin
                g = $urandom_range(1, MIN_CNT + 1);
                pulse(g, $urandom_range(3, 8));
                exp_en += en_cycles(g);
                exp_clr++;
            end
            len = $urandom_range(MIN_CNT + 2, 256);
            pulse(len, 6);
            exp_en += en_cycles(len);
            exp_clr++;
            n_chk++; if ({n_val, done, n_ld - b_ld} !== {8'(len - 1), 1'b1, 32'd1}) $display("FAIL rand%0d_result L=%0d got=%0d/%b/%0d exp=%0d/1/1", it, len, n_val, done, n_ld - b_ld, len - 1); else n_pass++;
            n_chk++; if (n_en - b_en !== exp_en) $display("FAIL rand%0d_en_cycles got=%0d exp=%0d", it, n_en - b_en, exp_en); else n_pass++;
            n_chk++; if (n_clr - b_clr !== exp_clr) $display("FAIL rand%0d_clr_pulses got=%0d exp=%0d", it, n_clr - b_clr, exp_clr); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_overflow();
        test_arm_low();
        test_abort();
        test_rst_mid();
        test_boundary();
        test_random();
        n_chk++; if (n_excl !== 0) $display("FAIL strobe_exclusive got=%0d exp=0 overlapping cycles", n_excl); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/autobaud_ctrl.md
AUTOBAUD_CTRL -- requirements
Module: autobaud_ctrl

Interface
REQ-001 Parameter MIN_CNT, default 4, minimum valid start-bit count; shorter low pulses are glitches.
REQ-002 clk  input  1  single clock, shared with the baud counter and N register.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request one measurement; sampled in IDLE, DONE and ERR only.
REQ-005 abort  input  1  cancel any measurement in progress.
REQ-006 rx  input  1  raw serial line, asynchronous to clk; idles high.
REQ-007 cnt_q  input  8  current baud-counter value.
REQ-008 cnt_en  output  1  counter increment enable.
REQ-009 cnt_rst  output  1  counter clear (feeds the counter's asynchronous reset).
REQ-010 ld_en  output  1  N register load enable.
REQ-011 busy  output  1  measurement in progress.
REQ-012 done  output  1  N holds a valid measurement.
REQ-013 err  output  1  start bit overran the 8-bit counter.

Function
REQ-014 Two-flop synchronizer: rx to rx_s; one further flop rx_d; falling edge = rx_d & ~rx_s.
REQ-015 FSM states: IDLE, ARM, WAIT_FALL, CLEAR, MEASURE, LOAD, DONE, ERR; one-hot encoded.
REQ-016 IDLE: start=1 -> ARM.
REQ-017 ARM: rx_s=1 -> WAIT_FALL; a line already low is never measured mid-bit.
REQ-018 WAIT_FALL: falling edge -> CLEAR.
REQ-019 CLEAR: exactly one cycle; cnt_rst=1; -> MEASURE.
REQ-020 MEASURE: cnt_en=1 every cycle in this state, including the exit cycle.
REQ-021 MEASURE exits are evaluated in this priority order:
  - rx_s=1 and cnt_q < MIN_CNT -> WAIT_FALL (glitch; no load, no flag).
  - rx_s=1 otherwise -> LOAD.
  - rx_s=0 and cnt_q=8'hFF -> ERR.
REQ-022 LOAD: exactly one cycle; ld_en=1, cnt_en=0; -> DONE.
REQ-023 DONE: done=1 held; start=1 -> ARM, done falls on entry to ARM.
REQ-024 ERR: err=1 held; start=1 -> ARM; ld_en never asserts on an error path.
REQ-025 start is ignored in ARM, WAIT_FALL, CLEAR, MEASURE and LOAD.
REQ-026 abort=1 in any state other than IDLE -> IDLE next edge; abort has priority over every other transition.
REQ-027 busy=1 in ARM, WAIT_FALL, CLEAR, MEASURE and LOAD, else 0.
REQ-028 Every output is a direct state-flop output or an OR of state flops (no glitches on cnt_rst).
REQ-029 Result rule: an rx_s low interval of L cycles loads N = L-1 (valid for MIN_CNT+2 <= L <= 256).
REQ-030 cnt_en, cnt_rst and ld_en are mutually exclusive in every cycle.

Reset
REQ-031 rst=1: state=IDLE, synchronizer flops and rx_d=1.
REQ-032 rst=1: cnt_en, cnt_rst, ld_en, busy, done and err all 0.
REQ-033 rst asserted mid-measurement takes effect immediately; no ld_en pulse follows release.

Structure
REQ-034 A shared package holds the state one-hot indices, the state width, the counter width (8) and the default MIN_CNT.
REQ-035 The rx synchronizer/edge detector is one sub-module, rx_sync_edge (outputs rx_s and fall).
REQ-036 The datapath counter and N register are instantiated outside this block, alongside it.

Verification
REQ-037 start, then rx_s low 100 cycles -> one cnt_rst pulse, 99 cnt_en cycles, one ld_en pulse, N=99, done=1, busy=0.
REQ-038 rx_s low 3 cycles, then low 50 cycles -> the first pulse is a glitch (no ld_en, stays busy); second pulse gives N=49, done=1.
REQ-039 rx_s low 300 cycles -> err=1 after cnt_q reaches 8'hFF, no ld_en, N unchanged; start with rx high -> ARM, err=0.
REQ-040 rx low when start arrives -> stays ARM until rx high; the next falling edge is measured.
REQ-041 abort at MEASURE cycle 20 -> IDLE next edge, cnt_en=0, no ld_en, busy=0.
REQ-042 rst at MEASURE cycle 20 -> all outputs 0 immediately; after release stays IDLE with no spurious pulses.
